// File: rtl/gbus_ap_arbiter_if.sv
// Generic-bus request/response bundle shared by the core, debug and slave sides of the
// AHB-AP arbiter. The master drives the request; the slave returns rdata/busy.
interface gbus_ap_arbiter_if;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        busy;

  modport master (output ren, wen, addr, wdata, byte_en, input rdata, busy);
  modport slave  (input ren, wen, addr, wdata, byte_en, output rdata, busy);
endinterface

// File: rtl/gbus_ap_arbiter.sv
// Two-master generic-bus arbiter (core vs JTAG AHB-AP) with fairness-bounded debug priority
// and burst lock. Define GBUS_ARB_TIMEOUT_EN to add the stuck-slave timeout.
module gbus_ap_arbiter #(
  parameter int unsigned MAX_DBG_RUN = 4
`ifdef GBUS_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              AFT_CLK,
  input  logic              nRST,
  gbus_ap_arbiter_if.slave  core,
  gbus_ap_arbiter_if.slave  dbg,
  gbus_ap_arbiter_if.master slv,
  input  logic              dbg_lock,
  output logic              grant_dbg,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int unsigned RunW = $clog2(MAX_DBG_RUN + 1);
  localparam logic [31:0] TmoRdata = 32'hBAD0_BAD0;

  typedef enum logic [1:0] {StIdle, StGntCore, StGntDbg} state_e;

  state_e          state_q, state_d, arb_state;
  logic [RunW-1:0] run_cnt_q, run_cnt_d;

  logic        core_req, dbg_req, dbg_wins;
  logic        own_ren, own_wen, own_req, own_busy;
  logic [31:0] own_addr, own_wdata, own_rdata;
  logic [3:0]  own_be;
  logic        slv_ren, slv_wen, cpl, tmo, done;

  assign core_req = core.ren | core.wen;
  assign dbg_req  = dbg.ren | dbg.wen;

  always_comb begin
    own_ren   = 1'b0;
    own_wen   = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    own_be    = '0;
    case (state_q)
      StGntCore: begin
        own_ren   = core.ren;
        own_wen   = core.wen;
        own_addr  = core.addr;
        own_wdata = core.wdata;
        own_be    = core.byte_en;
      end
      StGntDbg: begin
        own_ren   = dbg.ren;
        own_wen   = dbg.wen;
        own_addr  = dbg.addr;
        own_wdata = dbg.wdata;
        own_be    = dbg.byte_en;
      end
      default: ;
    endcase
  end

  // A simultaneous ren&wen is treated as a write.
  assign own_req = own_ren | own_wen;
  assign slv_wen = own_wen & ~tmo;
  assign slv_ren = own_ren & ~own_wen & ~tmo;
  assign cpl     = (slv_ren | slv_wen) & ~slv.busy;
  assign done    = cpl | tmo;

  assign slv.ren     = slv_ren;
  assign slv.wen     = slv_wen;
  assign slv.addr    = own_addr;
  assign slv.wdata   = own_wdata;
  assign slv.byte_en = own_be;

  assign own_busy  = tmo ? 1'b0 : slv.busy;
  assign own_rdata = tmo ? TmoRdata : slv.rdata;

  assign core.busy  = (state_q == StGntCore) ? own_busy : 1'b1;
  assign core.rdata = (state_q == StGntCore) ? own_rdata : '0;
  assign dbg.busy   = (state_q == StGntDbg) ? own_busy : 1'b1;
  assign dbg.rdata  = (state_q == StGntDbg) ? own_rdata : '0;
  assign grant_dbg  = (state_q == StGntDbg);

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!core_req || (state_q == StGntCore && done)) begin
      run_cnt_d = '0;
    end else if (state_q == StGntDbg && done && !dbg_lock &&
                 run_cnt_q != RunW'(MAX_DBG_RUN)) begin
      run_cnt_d = run_cnt_q + RunW'(1);
    end
  end

  // Arbitrate on the post-completion run count so the limiting grant hands over immediately.
  assign dbg_wins = dbg_req & ~(core_req & (run_cnt_d == RunW'(MAX_DBG_RUN)));

  always_comb begin
    if (dbg_wins) begin
      arb_state = StGntDbg;
    end else if (core_req) begin
      arb_state = StGntCore;
    end else begin
      arb_state = StIdle;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: state_d = arb_state;
      StGntCore, StGntDbg: begin
        if (!own_req) begin
          state_d = StIdle;
        end else if (done) begin
          state_d = (state_q == StGntDbg && dbg_lock) ? StGntDbg : arb_state;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge AFT_CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StIdle;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

`ifdef GBUS_ARB_TIMEOUT_EN
  localparam int unsigned ToW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_err_q, timeout_err_d;

  assign tmo = own_req & slv.busy & (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (done || !own_req || state_d != state_q) begin
      to_cnt_d = '0;
    end else if (slv.busy) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
    timeout_err_d = (timeout_err_q & ~err_clr) | tmo;
  end

  always_ff @(posedge AFT_CLK or negedge nRST) begin
    if (!nRST) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign tmo            = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_gbus_ap_arbiter.sv
// Scoreboard bench for gbus_ap_arbiter: behavioural core/debug masters and slave, with
// expected completions queued in arbitration order and checked as they happen.
module tb_gbus_ap_arbiter;

  typedef struct {
    bit          wr;
    bit          both;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          lock;
  } tx_t;

  typedef struct {
    bit          dbg;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    bit          tmo;
  } exp_t;

  logic clk = 1'b0;
  logic nRST;
  logic dbg_lock;
  logic grant_dbg;
  logic timeout_err;
  logic err_clr;

  gbus_ap_arbiter_if core_bus ();
  gbus_ap_arbiter_if dbg_bus ();
  gbus_ap_arbiter_if slv_bus ();

  gbus_ap_arbiter #(
    .MAX_DBG_RUN(4)
`ifdef GBUS_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .AFT_CLK    (clk),
    .nRST       (nRST),
    .core       (core_bus),
    .dbg        (dbg_bus),
    .slv        (slv_bus),
    .dbg_lock   (dbg_lock),
    .grant_dbg  (grant_dbg),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  tx_t  core_q[$];
  tx_t  dbg_q[$];
  exp_t sb[$];
  int   dbg_cpl_cyc[$];
  tx_t  core_cur, dbg_cur;
  bit   core_cur_v = 0, dbg_cur_v = 0;
  bit   core_done_f = 0, dbg_done_f = 0;
  bit   dbg_kill = 0;
  bit   slv_stuck = 0, rnd_en = 0, rnd_busy = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] wd_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  function automatic logic [3:0] be_of(input logic [31:0] a);
    return a[5:2] ^ 4'hA;
  endfunction

  task automatic send(input bit d, input bit wr, input bit both, input logic [31:0] a,
                      input bit lk);
    tx_t t;
    t.wr = wr; t.both = both; t.addr = a; t.wdata = wd_of(a); t.be = be_of(a); t.lock = lk;
    if (d) dbg_q.push_back(t);
    else core_q.push_back(t);
  endtask

  task automatic expect_tx(input bit d, input bit wr, input logic [31:0] a, input bit tmo,
                           input logic [31:0] rd);
    exp_t e;
    e.dbg = d; e.wr = wr; e.addr = a; e.wdata = wd_of(a); e.be = be_of(a);
    e.tmo = tmo; e.rdata = rd;
    sb.push_back(e);
  endtask

  // Slave model: read data is a fixed function of the address.
  assign slv_bus.busy  = slv_stuck | rnd_busy;
  assign slv_bus.rdata = slv_bus.ren ? (slv_bus.addr ^ 32'h1234_5678) : 32'h0;

  always @(posedge clk) begin
    cyc++;
    #1;
    rnd_busy = rnd_en && ($urandom_range(0, 2) == 0);
  end

  always @(posedge clk) begin
    #1;
    if (core_cur_v && core_done_f) core_cur_v = 0;
    if (!core_cur_v && core_q.size() > 0) begin
      core_cur = core_q.pop_front();
      core_cur_v = 1;
    end
    core_bus.ren     = core_cur_v && (!core_cur.wr || core_cur.both);
    core_bus.wen     = core_cur_v && core_cur.wr;
    core_bus.addr    = core_cur_v ? core_cur.addr : 32'h0;
    core_bus.wdata   = core_cur_v ? core_cur.wdata : 32'h0;
    core_bus.byte_en = core_cur_v ? core_cur.be : 4'h0;
  end

  always @(posedge clk) begin
    #1;
    if (dbg_cur_v && dbg_done_f) dbg_cur_v = 0;
    if (dbg_kill) begin
      dbg_cur_v = 0;
      dbg_kill = 0;
    end
    if (!dbg_cur_v && dbg_q.size() > 0) begin
      dbg_cur = dbg_q.pop_front();
      dbg_cur_v = 1;
    end
    dbg_bus.ren     = dbg_cur_v && (!dbg_cur.wr || dbg_cur.both);
    dbg_bus.wen     = dbg_cur_v && dbg_cur.wr;
    dbg_bus.addr    = dbg_cur_v ? dbg_cur.addr : 32'h0;
    dbg_bus.wdata   = dbg_cur_v ? dbg_cur.wdata : 32'h0;
    dbg_bus.byte_en = dbg_cur_v ? dbg_cur.be : 4'h0;
    dbg_lock        = dbg_cur_v && dbg_cur.lock;
  end

  task automatic sb_check(input bit d);
    exp_t e;
    if (sb.size() == 0) begin
      chk_eq("sb_unexpected_cpl", {31'h0, d}, 32'hFFFF_FFFF);
      return;
    end
    e = sb.pop_front();
    chk_eq("sb_master", {31'h0, d}, {31'h0, e.dbg});
    chk_eq("sb_addr", slv_bus.addr, e.addr);
    chk_eq("sb_byte_en", {28'h0, slv_bus.byte_en}, {28'h0, e.be});
    if (e.tmo) begin
      chk_eq("tmo_slv_req", {30'h0, slv_bus.ren, slv_bus.wen}, 32'h0);
      chk_eq("tmo_rdata", d ? dbg_bus.rdata : core_bus.rdata, e.rdata);
    end else if (e.wr) begin
      chk_eq("sb_wen", {31'h0, slv_bus.wen}, 32'h1);
      chk_eq("sb_ren_masked", {31'h0, slv_bus.ren}, 32'h0);
      chk_eq("sb_wdata", slv_bus.wdata, e.wdata);
    end else begin
      chk_eq("sb_rdata", d ? dbg_bus.rdata : core_bus.rdata, e.rdata);
    end
  endtask

  always @(negedge clk) begin
    core_done_f = 0;
    dbg_done_f = 0;
    if (nRST) begin
      if ((core_bus.ren || core_bus.wen) && grant_dbg)
        chk_eq("core_busy_nonowner", {31'h0, core_bus.busy}, 32'h1);
      if ((dbg_bus.ren || dbg_bus.wen) && !grant_dbg)
        chk_eq("dbg_busy_nonowner", {31'h0, dbg_bus.busy}, 32'h1);
      if ((core_bus.ren || core_bus.wen) && !core_bus.busy) begin
        core_done_f = 1;
        sb_check(1'b0);
      end
      if ((dbg_bus.ren || dbg_bus.wen) && !dbg_bus.busy) begin
        dbg_done_f = 1;
        dbg_cpl_cyc.push_back(cyc);
        sb_check(1'b1);
      end
    end
  end

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((sb.size() != 0 || core_q.size() != 0 || dbg_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain_left", sb.size(), 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_eq({tag, "_slv_req"}, {30'h0, slv_bus.ren, slv_bus.wen}, 32'h0);
    chk_eq({tag, "_busy"}, {30'h0, core_bus.busy, dbg_bus.busy}, 32'h3);
    chk_eq({tag, "_grant_dbg"}, {31'h0, grant_dbg}, 32'h0);
  endtask

  initial begin
    int k;
    int g_cyc;
    nRST = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    chk_eq("rst_slv_addr", slv_bus.addr, 32'h0);
    chk_eq("rst_slv_wdata", slv_bus.wdata, 32'h0);
    chk_eq("rst_slv_be", {28'h0, slv_bus.byte_en}, 32'h0);
    chk_eq("rst_core_rdata", core_bus.rdata, 32'h0);
    chk_eq("rst_dbg_rdata", dbg_bus.rdata, 32'h0);
    chk_eq("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
    #1 nRST = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_rst");

    // Simultaneous requests: debug first, one-cycle arbitration latency.
    rnd_en = 1;
    send(1'b0, 1'b0, 1'b0, 32'h40, 1'b0);
    send(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_tx(1'b1, 1'b0, 32'h0, 1'b0, 32'h1234_5678);
    expect_tx(1'b0, 1'b0, 32'h40, 1'b0, 32'h40 ^ 32'h1234_5678);
    @(negedge clk);
    chk_eq("arb_latency_idle", {31'h0, grant_dbg}, 32'h0);
    @(negedge clk);
    chk_eq("arb_grant_dbg", {31'h0, grant_dbg}, 32'h1);
    drain(100);

    // Fairness: four debug reads, then the waiting core write, then the rest.
    send(1'b0, 1'b1, 1'b1, 32'h80, 1'b0);
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 1'b0, 32'h10 + 32'(4 * i), 1'b0);
    for (int i = 0; i < 4; i++)
      expect_tx(1'b1, 1'b0, 32'h10 + 32'(4 * i), 1'b0, (32'h10 + 32'(4 * i)) ^ 32'h1234_5678);
    expect_tx(1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    for (int i = 4; i < 6; i++)
      expect_tx(1'b1, 1'b0, 32'h10 + 32'(4 * i), 1'b0, (32'h10 + 32'(4 * i)) ^ 32'h1234_5678);
    drain(200);

    // Locked debug burst holds the bus against a waiting core, with no idle gaps.
    rnd_en = 0;
    dbg_cpl_cyc.delete();
    send(1'b0, 1'b1, 1'b0, 32'h300, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 1'b1);
      expect_tx(1'b1, 1'b1, 32'h100 + 32'(4 * i), 1'b0, 32'h0);
    end
    expect_tx(1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    drain(100);
    chk_eq("lock_cpl_count", dbg_cpl_cyc.size(), 32'd8);
    if (dbg_cpl_cyc.size() == 8) chk_eq("lock_no_bubble", dbg_cpl_cyc[7] - dbg_cpl_cyc[0], 32'd7);

    // Debug abort mid-transfer, pending core takes over after one IDLE cycle.
    slv_stuck = 1;
    send(1'b1, 1'b0, 1'b0, 32'h2C0, 1'b0);
    send(1'b0, 1'b0, 1'b0, 32'h2D0, 1'b0);
    expect_tx(1'b0, 1'b0, 32'h2D0, 1'b0, 32'h2D0 ^ 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    chk_eq("abort_granted", {31'h0, grant_dbg}, 32'h1);
    chk_eq("abort_slv_ren_before", {31'h0, slv_bus.ren}, 32'h1);
    dbg_kill = 1;
    @(negedge clk);
    chk_eq("abort_slv_ren_drop", {30'h0, slv_bus.ren, slv_bus.wen}, 32'h0);
    @(negedge clk);
    chk_idle_outputs("abort_idle");
    #1 slv_stuck = 0;
    @(negedge clk);
    chk_eq("abort_core_grant_addr", slv_bus.addr, 32'h2D0);
    drain(50);

`ifdef GBUS_ARB_TIMEOUT_EN
    // Stuck slave: forced completion on the 16th busy cycle, sticky error flag.
    #1 slv_stuck = 1;
    dbg_cpl_cyc.delete();
    send(1'b1, 1'b0, 1'b0, 32'h200, 1'b0);
    expect_tx(1'b1, 1'b0, 32'h200, 1'b1, 32'hBAD0_BAD0);
    k = 0;
    while (!grant_dbg && k < 10) begin
      @(negedge clk);
      k++;
    end
    g_cyc = cyc;
    chk_eq("tmo_grant", {31'h0, grant_dbg}, 32'h1);
    drain(60);
    chk_eq("tmo_cpl_count", dbg_cpl_cyc.size(), 32'd1);
    if (dbg_cpl_cyc.size() == 1) chk_eq("tmo_cycles", dbg_cpl_cyc[0] - g_cyc, 32'd15);
    chk_eq("tmo_err_set", {31'h0, timeout_err}, 32'h1);
    @(negedge clk);
    chk_eq("tmo_err_sticky", {31'h0, timeout_err}, 32'h1);
    #1 err_clr = 1'b1;
    @(negedge clk);
    chk_eq("tmo_err_clr", {31'h0, timeout_err}, 32'h0);
    #1 err_clr = 1'b0;
    slv_stuck = 0;
    @(negedge clk);
`endif

    // Reset during a transfer: outputs fall immediately, transfer is dropped.
    #1 slv_stuck = 1;
    send(1'b1, 1'b0, 1'b0, 32'h3F0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_eq("rst_mid_granted", {31'h0, grant_dbg}, 32'h1);
    #1 nRST = 1'b0;
    dbg_kill = 1;
    #1;
    chk_idle_outputs("rst_mid");
    @(negedge clk);
    #1 nRST = 1'b1;
    slv_stuck = 0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("rst_mid_after");
    chk_eq("sb_empty_end", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
